display_mux_pwm: RTL

DISPLAY_MUX_PWM -- requirements
Module: display_mux_pwm

---
 rtl/display_mux_pwm.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/display_mux_pwm.sv
// Multiplexed 7-segment display driver: digit scan with frame-latched inputs,
// 15-step brightness PWM, and per-digit blink, blank and decimal-point control.
module display_mux_pwm #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 250
) (
  input  logic                    CLK100MHZ,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] DIGITS,
  input  logic [NUM_DIGITS-1:0]   DP_MASK,
  input  logic [NUM_DIGITS-1:0]   BLANK_MASK,
  input  logic [NUM_DIGITS-1:0]   BLINK_MASK,
  input  logic [3:0]              BRIGHT,
  output logic                    CA,
  output logic                    CB,
  output logic                    CC,
  output logic                    CD,
  output logic                    CE,
  output logic                    CF,
  output logic                    CG,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   AN
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
  localparam logic [3:0]       PWM_LAST = 4'd14;

  logic [PRE_W-1:0]        r_presc;
  logic [IDX_W-1:0]        r_index;
  logic [3:0]              r_pwm;
  logic [BLK_W-1:0]        r_blink_cnt;
  logic                    r_blink_phase;
  logic [4*NUM_DIGITS-1:0] r_sh_digits;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic [NUM_DIGITS-1:0]   r_sh_blink;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;

  logic                    w_tick;
  logic                    w_frame_wrap;
  logic                    w_pwm_on;
  logic                    w_dark;
  logic [3:0]              w_nibble;
  logic [6:0]              w_glyph;
  logic [NUM_DIGITS-1:0]   w_an_lit;

  assign w_tick       = (r_presc == PRE_LAST);
  assign w_frame_wrap = w_tick && (r_index == IDX_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK100MHZ) begin
    if (!reset) begin
      r_presc       <= '0;
      r_index       <= '0;
      r_pwm         <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      // NOTE: shadow registers are reset too, so the first frame after reset shows defined content.
      r_sh_digits   <= '0;
      r_sh_dp       <= '0;
      r_sh_blank    <= '0;
      r_sh_blink    <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
      r_pwm   <= (r_pwm == PWM_LAST) ? 4'd0 : r_pwm + 4'd1;
      if (w_tick) begin
        r_index <= (r_index == IDX_LAST) ? '0 : r_index + IDX_W'(1);
        if (r_blink_cnt == BLK_LAST) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + BLK_W'(1);
        end
      end
      // Inputs are captured only as the scan returns to digit 0, so a frame is never torn.
      if (w_frame_wrap) begin
        r_sh_digits <= DIGITS;
        r_sh_dp     <= DP_MASK;
        r_sh_blank  <= BLANK_MASK;
        r_sh_blink  <= BLINK_MASK;
      end
    end
  end

  // NOTE: every signal gets a default first, so no path through the block can infer a latch.
  always_comb begin
    w_nibble = r_sh_digits[4*int'(r_index) +: 4];
    w_pwm_on = (BRIGHT == 4'hF) || (r_pwm < BRIGHT);
    w_dark   = r_sh_blank[r_index] || (r_sh_blink[r_index] && r_blink_phase) || !w_pwm_on;
    w_an_lit = '1;
    w_an_lit[r_index] = 1'b0;
    w_glyph  = 7'b0000000;
    case (w_nibble) // active-high {a,b,c,d,e,f,g}
      4'h0: w_glyph = 7'b1111110;
      4'h1: w_glyph = 7'b0110000;
      4'h2: w_glyph = 7'b1101101;
      4'h3: w_glyph = 7'b1111001;
      4'h4: w_glyph = 7'b0110011;
      4'h5: w_glyph = 7'b1011011;
      4'h6: w_glyph = 7'b1011111;
      4'h7: w_glyph = 7'b1110000;
      4'h8: w_glyph = 7'b1111111;
      4'h9: w_glyph = 7'b1111011;
      4'hA: w_glyph = 7'b1110111;
      4'hB: w_glyph = 7'b0011111;
      4'hC: w_glyph = 7'b1001110;
      4'hD: w_glyph = 7'b0111101;
      4'hE: w_glyph = 7'b1001111;
      4'hF: w_glyph = 7'b1000111;
      default: w_glyph = 7'b0000000;
    endcase
  end

  // Anodes and cathodes share one register stage so segments never lead a dark anode.
  always_ff @(posedge CLK100MHZ) begin
    if (!reset || w_dark) begin
      r_an  <= '1;
      r_seg <= '1;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_lit;
      r_seg <= ~w_glyph;
      r_dp  <= ~r_sh_dp[r_index];
    end
  end

  assign {CA, CB, CC, CD, CE, CF, CG} = r_seg;
  assign DP = r_dp;
  assign AN = r_an;

endmodule
